// File: rtl/mux_scan_nx1_pkg.sv
// Shared mode/state encodings and sizing helper for the scanning multiplexer.
package mux_scan_nx1_pkg;

    localparam logic [0:0] MODE_MANUAL = 1'b0;
    localparam logic [0:0] MODE_SCAN   = 1'b1;

    localparam logic [0:0] S_MANUAL    = 1'b0;
    localparam logic [0:0] S_SCAN      = 1'b1;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-way packed-bus selector; out-of-range index picks channel N-1.
module mux_nx1 #(
    parameter  int unsigned N  = 5,
    parameter  int unsigned W  = 1,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N*W-1:0] data,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   data_c
);

    // Last channel is the default, so any index >= N-1 lands there.
    always_comb begin
        data_c = data[(N-1)*W +: W];
        for (int unsigned k = 0; k < N - 1; k++) begin
            if (32'(sel) == k) begin
                data_c = data[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-channel mux with manual select and timed auto-scan modes.
module mux_scan_nx1
    import mux_scan_nx1_pkg::*;
#(
    parameter  int unsigned N     = 5,
    parameter  int unsigned W     = 1,
    parameter  int unsigned DWELL = 4,
    localparam int unsigned SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] data_in,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           enable,
    output logic [W-1:0]   data_out,
    output logic [SW-1:0]  ch_out,
    output logic           ch_valid
);

    localparam int unsigned   CW       = clog2_min1(DWELL);
    localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [0:0]    state_q;
    logic [0:0]    state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [SW-1:0] ch_nxt;
    logic [SW-1:0] sel_ok;
    logic [W-1:0]  data_nxt;

    // Next state, next channel and dwell counter.
    always_comb begin
        state_nxt = mode;
        ch_nxt    = ch_out;
        cnt_nxt   = cnt_q;
        sel_ok    = (32'(sel) < N) ? sel : CH_LAST;

        if (state_q == S_MANUAL && mode == MODE_SCAN) begin
            // Entering scan restarts the dwell so the current channel gets a full slot.
            cnt_nxt = '0;
        end else if (enable) begin
            if (mode == MODE_MANUAL) begin
                ch_nxt  = sel_ok;
                cnt_nxt = '0;
            end else if (cnt_q == CNT_LAST) begin
                ch_nxt  = (ch_out == CH_LAST) ? '0 : ch_out + SW'(1);
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_q + CW'(1);
            end
        end
    end

    // Data for the channel that will be current after this edge.
    mux_nx1 #(
        .N (N),
        .W (W)
    ) u_mux (
        .data   (data_in),
        .sel    (ch_nxt),
        .data_c (data_nxt)
    );

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_MANUAL;
            cnt_q    <= '0;
            ch_out   <= '0;
            data_out <= '0;
            ch_valid <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            ch_out   <= ch_nxt;
            data_out <= data_nxt;
            ch_valid <= (ch_nxt != ch_out);
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: default config plus a wide DWELL=1 config.
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    int          tests = 0;
    int          fails = 0;

    // Default instance: N=5, W=1, DWELL=4
    logic        a_reset;
    logic [4:0]  a_data_in;
    logic [2:0]  a_sel;
    logic        a_mode;
    logic        a_enable;
    logic [0:0]  a_data_out;
    logic [2:0]  a_ch_out;
    logic        a_ch_valid;

    // Wide instance: N=8, W=4, DWELL=1
    logic        b_reset;
    logic [31:0] b_data_in;
    logic [2:0]  b_sel;
    logic        b_mode;
    logic        b_enable;
    logic [3:0]  b_data_out;
    logic [2:0]  b_ch_out;
    logic        b_ch_valid;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N(5), .W(1), .DWELL(4)) dut_a (
        .clk      (clk),
        .reset    (a_reset),
        .data_in  (a_data_in),
        .sel      (a_sel),
        .mode     (a_mode),
        .enable   (a_enable),
        .data_out (a_data_out),
        .ch_out   (a_ch_out),
        .ch_valid (a_ch_valid)
    );

    mux_scan_nx1 #(.N(8), .W(4), .DWELL(1)) dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .data_in  (b_data_in),
        .sel      (b_sel),
        .mode     (b_mode),
        .enable   (b_enable),
        .data_out (b_data_out),
        .ch_out   (b_ch_out),
        .ch_valid (b_ch_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned exp_ch;
        int          pulses;
        logic        exp_d;

        a_reset = 1'b1; a_data_in = '0; a_sel = '0; a_mode = 1'b0; a_enable = 1'b0;
        b_reset = 1'b1; b_data_in = 32'h7654_3210; b_sel = '0; b_mode = 1'b1; b_enable = 1'b1;

        // 1. reset then manual select of channel 2
        tick();
        a_data_in = 5'b00100; a_sel = 3'd2; a_enable = 1'b1;
        tick();
        check("rst_data", 32'(a_data_out), 32'd0);
        check("rst_ch",   32'(a_ch_out),   32'd0);
        check("rst_vld",  32'(a_ch_valid), 32'd0);
        a_reset = 1'b0;
        tick();
        check("man_data", 32'(a_data_out), 32'd1);
        check("man_ch",   32'(a_ch_out),   32'd2);
        check("man_vld",  32'(a_ch_valid), 32'd1);
        tick();
        check("man_vld_drop", 32'(a_ch_valid), 32'd0);
        check("man_ch_hold",  32'(a_ch_out),   32'd2);

        // 2. invalid selects route to channel 4
        a_data_in = 5'b10000;
        a_sel = 3'd5;
        tick();
        check("inv5_ch",   32'(a_ch_out),   32'd4);
        check("inv5_data", 32'(a_data_out), 32'd1);
        check("inv5_vld",  32'(a_ch_valid), 32'd1);
        a_sel = 3'd6;
        tick();
        check("inv6_ch",   32'(a_ch_out),   32'd4);
        check("inv6_data", 32'(a_data_out), 32'd1);
        check("inv6_vld",  32'(a_ch_valid), 32'd0);
        a_sel = 3'd7;
        tick();
        check("inv7_ch",   32'(a_ch_out),   32'd4);
        check("inv7_data", 32'(a_data_out), 32'd1);
        check("inv7_vld",  32'(a_ch_valid), 32'd0);

        // 3. scan from channel 0 through the wrap
        a_sel = 3'd0;
        tick();
        check("pre_scan_ch", 32'(a_ch_out), 32'd0);
        a_data_in = 5'b01010;
        a_mode = 1'b1;
        pulses = 0;
        for (int i = 0; i <= 20; i++) begin
            tick();
            exp_ch = (i / 4) % 5;
            exp_d  = a_data_in[exp_ch];
            check($sformatf("scan_ch[%0d]", i),   32'(a_ch_out),   32'(exp_ch));
            check($sformatf("scan_data[%0d]", i), 32'(a_data_out), 32'(exp_d));
            if (a_ch_valid) pulses++;
        end
        check("scan_pulses", 32'(pulses), 32'd5);

        // 4. reach ch 2 with counter 1, then freeze
        for (int i = 21; i <= 29; i++) tick();
        check("pre_freeze_ch", 32'(a_ch_out), 32'd2);
        a_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a_data_in = 5'(k * 3 + 1);
            exp_d = a_data_in[2];
            tick();
            check($sformatf("frz_ch[%0d]", k),   32'(a_ch_out),   32'd2);
            check($sformatf("frz_data[%0d]", k), 32'(a_data_out), 32'(exp_d));
        end
        a_enable = 1'b1;
        a_data_in = 5'b01000;
        tick();
        check("unfrz_ch0", 32'(a_ch_out), 32'd2);
        tick();
        check("unfrz_ch1", 32'(a_ch_out), 32'd2);
        tick();
        check("unfrz_adv",  32'(a_ch_out),   32'd3);
        check("unfrz_vld",  32'(a_ch_valid), 32'd1);
        check("unfrz_data", 32'(a_data_out), 32'd1);

        // 5. scan -> manual switch, then mid-scan reset
        a_mode = 1'b0; a_sel = 3'd1; a_data_in = 5'b00010;
        tick();
        check("sw_ch",   32'(a_ch_out),   32'd1);
        check("sw_data", 32'(a_data_out), 32'd1);
        check("sw_vld",  32'(a_ch_valid), 32'd1);
        a_mode = 1'b1; a_data_in = 5'b11111;
        tick();
        tick();
        a_reset = 1'b1;
        tick();
        check("mrst_ch",   32'(a_ch_out),   32'd0);
        check("mrst_data", 32'(a_data_out), 32'd0);
        check("mrst_vld",  32'(a_ch_valid), 32'd0);
        a_reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("post_rst_hold[%0d]", j), 32'(a_ch_out), 32'd0);
        end
        tick();
        check("post_rst_adv", 32'(a_ch_out),   32'd1);
        check("post_rst_vld", 32'(a_ch_valid), 32'd1);

        // 6. wide config, DWELL=1, channel k carries value k
        b_reset = 1'b0;
        tick();
        check("wide_switch_ch", 32'(b_ch_out), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("wide_ch[%0d]", i),   32'(b_ch_out),   32'(i % 8));
            check($sformatf("wide_data[%0d]", i), 32'(b_data_out), 32'(i % 8));
            check($sformatf("wide_vld[%0d]", i),  32'(b_ch_valid), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
